// File: rtl/adc_trigger_sequencer.sv
// rtl/adc_trigger_sequencer.sv - round-robin ADC trigger sequencer with EOC watchdog
//
// Purpose: emits single-cycle ADC trigger pulses on a programmable period,
// tagging each pulse with a round-robin channel index. In free-run mode a
// trigger fires every period_q+1 cycles. In EOC-synchronised mode the
// sequencer waits for eoc_i after each period. A watchdog forces the trigger
// and counts an error if eoc_i never arrives.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   enable_i     1 = run, 0 = return to IDLE (channel index cleared)
//   sync_mode_i  0 = free-run, 1 = wait for EOC (latched per period)
//   period_i     period P, latched per period, 0 treated as 1
//   eoc_i        end-of-conversion pulse, only observed in WAIT_EOC
//   trigger_o    registered single-cycle trigger pulse
//   chan_o       channel of the latest trigger (holds between pulses)
//   busy_o       state != IDLE
//   timeout_o    pulses together with a watchdog-forced trigger
//   err_count_o  saturating count of watchdog timeouts
module adc_trigger_sequencer #(
    parameter int CounterWidth = 16,
    parameter int NumChannels  = 4,
    parameter int ChanWidth    = 2,
    parameter int TimeoutWidth = 12,
    parameter int TimeoutMax   = 4095
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    sync_mode_i,
    input  logic [CounterWidth-1:0] period_i,
    input  logic                    eoc_i,
    output logic                    trigger_o,
    output logic [ChanWidth-1:0]    chan_o,
    output logic                    busy_o,
    output logic                    timeout_o,
    output logic [7:0]              err_count_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        WAIT_EOC = 2'd2
    } state_t;

    localparam logic [ChanWidth-1:0]    LastChan = ChanWidth'(NumChannels - 1);
    localparam logic [TimeoutWidth-1:0] WdLimit  = TimeoutWidth'(TimeoutMax);

    state_t                  r_state;
    state_t                  w_next;
    logic [CounterWidth-1:0] r_cnt;
    logic [CounterWidth-1:0] r_period;
    logic                    r_mode;
    logic [TimeoutWidth-1:0] r_wd;
    logic [ChanWidth-1:0]    r_idx;
    logic                    r_trig;
    logic [ChanWidth-1:0]    r_chan;
    logic                    r_tmo;
    logic [7:0]              r_err;

    // w_fire: emit a trigger at this edge; w_tmo: it was forced by the
    // watchdog; w_latch: capture period_i/sync_mode_i for the next period.
    logic w_fire;
    logic w_tmo;
    logic w_latch;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_fire  = 1'b0;
        w_tmo   = 1'b0;
        w_latch = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable_i) begin
                    w_next  = COUNT;
                    w_latch = 1'b1;
                end
            end
            COUNT: begin
                // Disable outranks a trigger due in the same cycle.
                if (!enable_i) begin
                    w_next = IDLE;
                end else if (r_cnt == r_period) begin
                    if (r_mode) begin
                        w_next = WAIT_EOC;
                    end else begin
                        w_fire  = 1'b1;
                        w_latch = 1'b1;
                    end
                end
            end
            WAIT_EOC: begin
                // EOC is tested before the watchdog limit so a coincident
                // EOC is treated as a normal conversion, not a timeout.
                if (!enable_i) begin
                    w_next = IDLE;
                end else if (eoc_i) begin
                    w_next  = COUNT;
                    w_fire  = 1'b1;
                    w_latch = 1'b1;
                end else if (r_wd == WdLimit) begin
                    w_next  = COUNT;
                    w_fire  = 1'b1;
                    w_tmo   = 1'b1;
                    w_latch = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_period <= '0;
            r_mode   <= 1'b0;
            r_wd     <= '0;
            r_idx    <= '0;
            r_trig   <= 1'b0;
            r_chan   <= '0;
            r_tmo    <= 1'b0;
            r_err    <= '0;
        end else begin
            r_trig <= w_fire;
            r_tmo  <= w_tmo;

            if (w_next == IDLE) begin
                r_cnt <= '0;
            end else if (w_latch) begin
                r_cnt <= '0;
            end else if (r_state == COUNT && w_next == COUNT) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == WAIT_EOC && w_next == WAIT_EOC) begin
                r_wd <= r_wd + 1'b1;
            end else begin
                r_wd <= '0;
            end

            if (w_latch) begin
                r_period <= (period_i == '0) ? CounterWidth'(1) : period_i;
                r_mode   <= sync_mode_i;
            end

            if (w_next == IDLE) begin
                r_idx <= '0;
            end else if (w_fire) begin
                r_chan <= r_idx;
                r_idx  <= (r_idx == LastChan) ? '0 : r_idx + 1'b1;
            end

            if (w_tmo && r_err != 8'hFF) begin
                r_err <= r_err + 8'd1;
            end
        end
    end

    assign trigger_o   = r_trig;
    assign chan_o      = r_chan;
    assign busy_o      = (r_state != IDLE);
    assign timeout_o   = r_tmo;
    assign err_count_o = r_err;

endmodule

// File: tb/tb_adc_trigger_sequencer.sv
// tb/tb_adc_trigger_sequencer.sv - directed vector bench for adc_trigger_sequencer
module tb_adc_trigger_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        sync = 1'b0;
    logic [15:0] period = 16'd0;
    logic        eoc = 1'b0;
    logic        trig;
    logic [1:0]  chan;
    logic        busy;
    logic        tmo;
    logic [7:0]  err;

    adc_trigger_sequencer #(
        .CounterWidth(16),
        .NumChannels (4),
        .ChanWidth   (2),
        .TimeoutWidth(12),
        .TimeoutMax  (15)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (en),
        .sync_mode_i(sync),
        .period_i   (period),
        .eoc_i      (eoc),
        .trigger_o  (trig),
        .chan_o     (chan),
        .busy_o     (busy),
        .timeout_o  (tmo),
        .err_count_o(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        en;
        logic        sync;
        logic [15:0] period;
        logic        eoc;
        int          n;
        logic        trig;
        logic [1:0]  chan;
        logic        busy;
        logic        tmo;
        logic [7:0]  err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic e, input logic s, input logic [15:0] p, input logic c,
                       input int n, input logic t, input logic [1:0] ch, input logic b,
                       input logic tm, input logic [7:0] er);
        vec_t v;
        v.en = e; v.sync = s; v.period = p; v.eoc = c; v.n = n;
        v.trig = t; v.chan = ch; v.busy = b; v.tmo = tm; v.err = er;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic t, input logic [1:0] ch,
                         input logic b, input logic tm, input logic [7:0] er);
        checks++;
        if (trig === t && chan === ch && busy === b && tmo === tm && err === er) begin
            passed++;
        end else begin
            $display("FAIL %s: got trig=%0b chan=%0d busy=%0b tmo=%0b err=%0d, want trig=%0b chan=%0d busy=%0b tmo=%0b err=%0d",
                     name, trig, chan, busy, tmo, err, t, ch, b, tm, er);
        end
    endtask

    // Advance n edges and require exactly exp_pulses triggers among them.
    task automatic gap_check(input string name, input int n, input int exp_pulses);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (trig === 1'b1) seen++;
        end
        checks++;
        if (seen == exp_pulses) passed++;
        else $display("FAIL %s: got %0d trigger pulses, want %0d", name, seen, exp_pulses);
    endtask

    initial begin
        // Free-run P=9, then live reconfig, P=0, abort
        add(0,0,16'd9,0, 1, 0,2'd0,0,0,8'd0);
        add(1,0,16'd9,0, 1, 0,2'd0,1,0,8'd0);
        add(1,0,16'd9,0,10, 1,2'd0,1,0,8'd0);
        add(1,0,16'd9,0, 1, 0,2'd0,1,0,8'd0);
        add(1,0,16'd9,0, 9, 1,2'd1,1,0,8'd0);
        add(1,0,16'd9,0,10, 1,2'd2,1,0,8'd0);
        add(1,0,16'd9,0,10, 1,2'd3,1,0,8'd0);
        add(1,0,16'd9,0,10, 1,2'd0,1,0,8'd0);
        add(1,0,16'd9,0,10, 1,2'd1,1,0,8'd0);
        add(1,0,16'd3,0, 5, 0,2'd1,1,0,8'd0);
        add(1,0,16'd3,0, 5, 1,2'd2,1,0,8'd0);
        add(1,0,16'd3,0, 4, 1,2'd3,1,0,8'd0);
        add(1,0,16'd0,0, 4, 1,2'd0,1,0,8'd0);
        add(1,0,16'd0,0, 2, 1,2'd1,1,0,8'd0);
        add(1,0,16'd0,0, 1, 0,2'd1,1,0,8'd0);
        add(1,0,16'd0,0, 1, 1,2'd2,1,0,8'd0);
        add(1,0,16'd9,0, 2, 1,2'd3,1,0,8'd0);
        add(1,0,16'd9,0, 9, 0,2'd3,1,0,8'd0);
        add(0,0,16'd9,0, 1, 0,2'd3,0,0,8'd0);
        add(1,0,16'd2,0, 1, 0,2'd3,1,0,8'd0);
        add(1,0,16'd2,0, 3, 1,2'd0,1,0,8'd0);
        // Sync mode P=4: early EOC ignored, EOC 3 cycles into WAIT_EOC
        add(0,1,16'd4,0, 1, 0,2'd0,0,0,8'd0);
        add(1,1,16'd4,0, 1, 0,2'd0,1,0,8'd0);
        add(1,1,16'd4,1, 1, 0,2'd0,1,0,8'd0);
        add(1,1,16'd4,0, 4, 0,2'd0,1,0,8'd0);
        add(1,1,16'd4,0, 2, 0,2'd0,1,0,8'd0);
        add(1,1,16'd4,1, 1, 1,2'd0,1,0,8'd0);
        add(1,1,16'd4,0, 1, 0,2'd0,1,0,8'd0);
        // Watchdog timeouts, then EOC colliding with the limit
        add(1,1,16'd4,0,20, 1,2'd1,1,1,8'd1);
        add(1,1,16'd4,0,21, 1,2'd2,1,1,8'd2);
        add(1,1,16'd4,0,21, 1,2'd3,1,1,8'd3);
        add(1,1,16'd4,0,20, 0,2'd3,1,0,8'd3);
        add(1,1,16'd4,1, 1, 1,2'd0,1,0,8'd3);
        add(1,1,16'd4,0, 1, 0,2'd0,1,0,8'd3);

        rst = 1'b1;
        tick();
        tick();
        check("reset", 0, 2'd0, 0, 0, 8'd0);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            en     = vq[i].en;
            sync   = vq[i].sync;
            period = vq[i].period;
            eoc    = vq[i].eoc;
            if (vq[i].n > 1) gap_check($sformatf("gap%0d", i), vq[i].n - 1, 0);
            tick();
            check($sformatf("vec%0d", i), vq[i].trig, vq[i].chan, vq[i].busy, vq[i].tmo, vq[i].err);
        end

        // Saturation: sync mode P=0 times out every 18 cycles, 252 more needed.
        eoc = 1'b0;
        en  = 1'b0;
        tick();
        en = 1'b1; sync = 1'b1; period = 16'd0;
        tick();
        gap_check("sat_pulses", 18 * 252 - 1, 251);
        tick();
        check("sat_reach", 1, 2'd3, 1, 1, 8'd255);
        gap_check("sat_gap", 17, 0);
        tick();
        check("sat_hold", 1, 2'd0, 1, 1, 8'd255);

        // Reset while waiting for EOC
        for (int k = 0; k < 5; k++) tick();
        check("in_wait", 0, 2'd0, 1, 0, 8'd255);
        rst = 1'b1;
        en  = 1'b0;
        tick();
        check("rst_mid_wait", 0, 2'd0, 0, 0, 8'd0);
        rst = 1'b0;
        tick();
        check("post_rst_idle", 0, 2'd0, 0, 0, 8'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
